// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : adder_seq_pkg
// Brief   : Shared state encoding, control-word layout and defaults for the
//           adder operation sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
package adder_seq_pkg;

  localparam int c_def_data_width   = 64;
  localparam int c_def_addr_width   = 9;
  localparam int c_def_ctrl_width   = 8;
  localparam int c_def_id           = 3;
  localparam int c_def_drain_cycles = 10;
  localparam int c_def_timeout      = 2048;

  // Control word 1 carries the add/sub flag in its MSB, unit ID below it.
  localparam int c_ctrl_oper_bits = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CTRL_1   = 3'd1,
    ST_CTRL_2   = 3'd2,
    ST_CTRL_3   = 3'd3,
    ST_FEED     = 3'd4,
    ST_WAIT_RES = 3'd5,
    ST_DRAIN    = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

endpackage
`default_nettype wire

// File: rtl/adder_seq_limb_pipe.sv
`default_nettype none
// ============================================================================
// Module : adder_seq_limb_pipe
// Brief  : Two-stage read pipeline: tags each limb read, zero-masks operands
//          past their length and registers the limb onto the adder data bus.
// Rev    : 1.0 - initial release
// ============================================================================
module adder_seq_limb_pipe
  import adder_seq_pkg::*;
#(
  parameter int DATA_WIDTH = c_def_data_width,
  parameter int ADDR_WIDTH = c_def_addr_width
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_idx,
  input  logic [ADDR_WIDTH-1:0] i_len_a,
  input  logic [ADDR_WIDTH-1:0] i_len_b,
  input  logic                  i_last,
  input  logic [DATA_WIDTH-1:0] i_rd_data_a,
  input  logic [DATA_WIDTH-1:0] i_rd_data_b,
  output logic [DATA_WIDTH-1:0] o_data_a,
  output logic [DATA_WIDTH-1:0] o_data_b,
  output logic                  o_last,
  output logic                  o_wr_en
);

  logic                  s1_vld_q, s1_vld_d;
  logic                  s1_last_q, s1_last_d;
  logic                  s1_zero_a_q, s1_zero_a_d;
  logic                  s1_zero_b_q, s1_zero_b_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic                  last_q, last_d;
  logic                  wr_en_q, wr_en_d;

  always_comb begin
    s1_vld_d    = i_rd_en;
    s1_last_d   = i_rd_en & i_last;
    s1_zero_a_d = i_rd_en & (i_rd_idx > i_len_a);
    s1_zero_b_d = i_rd_en & (i_rd_idx > i_len_b);
    // Memory data is valid in the cycle after the read, alongside stage 1.
    data_a_d    = (s1_vld_q & ~s1_zero_a_q) ? i_rd_data_a : '0;
    data_b_d    = (s1_vld_q & ~s1_zero_b_q) ? i_rd_data_b : '0;
    last_d      = s1_vld_q & s1_last_q;
    wr_en_d     = s1_vld_q;
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_zero_a_q <= 1'b0;
      s1_zero_b_q <= 1'b0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      last_q      <= 1'b0;
      wr_en_q     <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      s1_zero_a_q <= s1_zero_a_d;
      s1_zero_b_q <= s1_zero_b_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      last_q      <= last_d;
      wr_en_q     <= wr_en_d;
    end
  end

  assign o_data_a = data_a_q;
  assign o_data_b = data_b_q;
  assign o_last   = last_q;
  assign o_wr_en  = wr_en_q;

endmodule
`default_nettype wire

// File: rtl/adder_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : adder_op_sequencer
// Brief  : Runs one add/sub command: three control words, a gapless limb feed,
//          then waits for the adder's last result, drains and reports done.
// Rev    : 1.0 - initial release
// ============================================================================
module adder_op_sequencer
  import adder_seq_pkg::*;
#(
  parameter int G_DATA_WIDTH   = c_def_data_width,
  parameter int G_ADDR_WIDTH   = c_def_addr_width,
  parameter int G_CTRL_WIDTH   = c_def_ctrl_width,
  parameter int G_ID           = c_def_id,
  parameter int G_DRAIN_CYCLES = c_def_drain_cycles,
  parameter int G_TIMEOUT      = c_def_timeout
) (
  input  logic                    r_clk,
  input  logic                    r_rst,
  input  logic                    pi_cmd_valid,
  output logic                    po_cmd_ready,
  input  logic                    pi_cmd_oper,
  input  logic [G_CTRL_WIDTH-1:0] pi_cmd_src_a,
  input  logic [G_CTRL_WIDTH-1:0] pi_cmd_src_b,
  input  logic [G_ADDR_WIDTH-1:0] pi_cmd_len_a,
  input  logic [G_ADDR_WIDTH-1:0] pi_cmd_len_b,
  output logic                    po_rd_en,
  output logic [G_ADDR_WIDTH-1:0] po_rd_addr,
  input  logic [G_DATA_WIDTH-1:0] pi_rd_data_a,
  input  logic [G_DATA_WIDTH-1:0] pi_rd_data_b,
  output logic [G_CTRL_WIDTH-1:0] po_ctrl_ch_A,
  output logic [G_CTRL_WIDTH-1:0] po_ctrl_ch_B,
  output logic                    po_ctrl_valid_n,
  output logic [G_DATA_WIDTH-1:0] po_data_A,
  output logic [G_DATA_WIDTH-1:0] po_data_B,
  output logic                    po_data_last,
  output logic                    po_data_wr_en,
  input  logic                    pi_res_wr_en,
  input  logic                    pi_res_last,
  output logic                    po_busy,
  output logic                    po_done,
  output logic                    po_err,
  output logic [G_ADDR_WIDTH:0]   po_res_limbs
);

  localparam int c_tmr_max = (G_TIMEOUT > G_DRAIN_CYCLES) ? G_TIMEOUT : G_DRAIN_CYCLES;
  localparam int c_tmr_w   = $clog2(c_tmr_max + 1);
  localparam logic [G_CTRL_WIDTH-1:0] c_id_word = G_CTRL_WIDTH'(G_ID);

  state_e                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    oper_q, oper_d;
  logic [G_CTRL_WIDTH-1:0] src_a_q, src_a_d;
  logic [G_CTRL_WIDTH-1:0] src_b_q, src_b_d;
  logic [G_ADDR_WIDTH-1:0] len_a_q, len_a_d;
  logic [G_ADDR_WIDTH-1:0] len_b_q, len_b_d;
  logic [G_ADDR_WIDTH-1:0] max_len_q, max_len_d;
  logic [G_ADDR_WIDTH-1:0] feed_cnt_q, feed_cnt_d;
  logic [c_tmr_w-1:0]      tmr_q, tmr_d;
  logic [G_ADDR_WIDTH:0]   res_limbs_q, res_limbs_d;
  logic                    res_seen_q, res_seen_d;
  logic                    err_q, err_d;

  logic w_accept;
  logic w_res_last;
  logic w_feed;
  logic w_feed_last;

  assign w_accept    = (state_q == ST_IDLE) & cmd_ready_q & pi_cmd_valid;
  assign w_res_last  = pi_res_wr_en & pi_res_last;
  assign w_feed      = (state_q == ST_FEED);
  assign w_feed_last = (feed_cnt_q == max_len_q);

  always_comb begin
    state_d     = state_q;
    oper_d      = oper_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    len_a_d     = len_a_q;
    len_b_d     = len_b_q;
    max_len_d   = max_len_q;
    feed_cnt_d  = feed_cnt_q;
    res_seen_d  = res_seen_q;
    err_d       = err_q;
    res_limbs_d = pi_res_wr_en ? res_limbs_q + (G_ADDR_WIDTH+1)'(1) : res_limbs_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d     = ST_CTRL_1;
          oper_d      = pi_cmd_oper;
          src_a_d     = pi_cmd_src_a;
          src_b_d     = pi_cmd_src_b;
          len_a_d     = pi_cmd_len_a;
          len_b_d     = pi_cmd_len_b;
          max_len_d   = (pi_cmd_len_a > pi_cmd_len_b) ? pi_cmd_len_a : pi_cmd_len_b;
          feed_cnt_d  = '0;
          res_limbs_d = '0;
          res_seen_d  = 1'b0;
          err_d       = 1'b0;
        end
      end
      ST_CTRL_1: state_d = ST_CTRL_2;
      ST_CTRL_2: state_d = ST_CTRL_3;
      ST_CTRL_3: state_d = ST_FEED;
      ST_FEED: begin
        // An adder that finishes before the feed ends skips WAIT_RES entirely.
        if (w_res_last) res_seen_d = 1'b1;
        if (w_feed_last) begin
          state_d = (res_seen_q | w_res_last) ? ST_DRAIN : ST_WAIT_RES;
        end else begin
          feed_cnt_d = feed_cnt_q + G_ADDR_WIDTH'(1);
        end
      end
      ST_WAIT_RES: begin
        if (w_res_last) begin
          state_d = ST_DRAIN;
        end else if (tmr_q == c_tmr_w'(G_TIMEOUT - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (tmr_q == c_tmr_w'(G_DRAIN_CYCLES - 1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // One timer serves WAIT_RES and DRAIN; it restarts on every state change.
    if (state_d != state_q) begin
      tmr_d = '0;
    end else if ((state_q == ST_WAIT_RES) || (state_q == ST_DRAIN)) begin
      tmr_d = tmr_q + c_tmr_w'(1);
    end else begin
      tmr_d = tmr_q;
    end

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      oper_q      <= 1'b0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      len_a_q     <= '0;
      len_b_q     <= '0;
      max_len_q   <= '0;
      feed_cnt_q  <= '0;
      tmr_q       <= '0;
      res_limbs_q <= '0;
      res_seen_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      oper_q      <= oper_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      len_a_q     <= len_a_d;
      len_b_q     <= len_b_d;
      max_len_q   <= max_len_d;
      feed_cnt_q  <= feed_cnt_d;
      tmr_q       <= tmr_d;
      res_limbs_q <= res_limbs_d;
      res_seen_q  <= res_seen_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    po_ctrl_valid_n = 1'b1;
    po_ctrl_ch_A    = '0;
    po_ctrl_ch_B    = '0;
    case (state_q)
      ST_CTRL_1: begin
        po_ctrl_valid_n = 1'b0;
        po_ctrl_ch_A    = {oper_q, c_id_word[G_CTRL_WIDTH-c_ctrl_oper_bits-1:0]};
        po_ctrl_ch_B    = c_id_word;
      end
      ST_CTRL_2: begin
        po_ctrl_ch_A = src_a_q;
        po_ctrl_ch_B = src_b_q;
      end
      default: ;
    endcase
  end

  assign po_rd_en     = w_feed;
  assign po_rd_addr   = w_feed ? feed_cnt_q : '0;
  assign po_cmd_ready = cmd_ready_q;
  assign po_busy      = (state_q != ST_IDLE);
  assign po_done      = (state_q == ST_DONE);
  assign po_err       = err_q;
  assign po_res_limbs = res_limbs_q;

  adder_seq_limb_pipe #(
    .DATA_WIDTH (G_DATA_WIDTH),
    .ADDR_WIDTH (G_ADDR_WIDTH)
  ) u_limb_pipe (
    .r_clk       (r_clk),
    .r_rst       (r_rst),
    .i_rd_en     (w_feed),
    .i_rd_idx    (feed_cnt_q),
    .i_len_a     (len_a_q),
    .i_len_b     (len_b_q),
    .i_last      (w_feed_last),
    .i_rd_data_a (pi_rd_data_a),
    .i_rd_data_b (pi_rd_data_b),
    .o_data_a    (po_data_A),
    .o_data_b    (po_data_B),
    .o_last      (po_data_last),
    .o_wr_en     (po_data_wr_en)
  );

endmodule
`default_nettype wire

// File: tb/tb_adder_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_adder_op_sequencer
// Brief  : Directed self-checking bench for the adder operation sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_adder_op_sequencer;

  localparam int c_dw    = 64;
  localparam int c_aw    = 9;
  localparam int c_cw    = 8;
  localparam int c_id    = 3;
  localparam int c_drain = 10;
  localparam int c_tmo   = 2048;

  logic            r_clk = 1'b0;
  logic            r_rst;
  logic            pi_cmd_valid;
  logic            po_cmd_ready;
  logic            pi_cmd_oper;
  logic [c_cw-1:0] pi_cmd_src_a, pi_cmd_src_b;
  logic [c_aw-1:0] pi_cmd_len_a, pi_cmd_len_b;
  logic            po_rd_en;
  logic [c_aw-1:0] po_rd_addr;
  logic [c_dw-1:0] pi_rd_data_a, pi_rd_data_b;
  logic [c_cw-1:0] po_ctrl_ch_A, po_ctrl_ch_B;
  logic            po_ctrl_valid_n;
  logic [c_dw-1:0] po_data_A, po_data_B;
  logic            po_data_last, po_data_wr_en;
  logic            pi_res_wr_en, pi_res_last;
  logic            po_busy, po_done, po_err;
  logic [c_aw:0]   po_res_limbs;

  int n_checks = 0;
  int n_fail   = 0;

  adder_op_sequencer #(
    .G_DATA_WIDTH   (c_dw),
    .G_ADDR_WIDTH   (c_aw),
    .G_CTRL_WIDTH   (c_cw),
    .G_ID           (c_id),
    .G_DRAIN_CYCLES (c_drain),
    .G_TIMEOUT      (c_tmo)
  ) dut (
    .r_clk           (r_clk),
    .r_rst           (r_rst),
    .pi_cmd_valid    (pi_cmd_valid),
    .po_cmd_ready    (po_cmd_ready),
    .pi_cmd_oper     (pi_cmd_oper),
    .pi_cmd_src_a    (pi_cmd_src_a),
    .pi_cmd_src_b    (pi_cmd_src_b),
    .pi_cmd_len_a    (pi_cmd_len_a),
    .pi_cmd_len_b    (pi_cmd_len_b),
    .po_rd_en        (po_rd_en),
    .po_rd_addr      (po_rd_addr),
    .pi_rd_data_a    (pi_rd_data_a),
    .pi_rd_data_b    (pi_rd_data_b),
    .po_ctrl_ch_A    (po_ctrl_ch_A),
    .po_ctrl_ch_B    (po_ctrl_ch_B),
    .po_ctrl_valid_n (po_ctrl_valid_n),
    .po_data_A       (po_data_A),
    .po_data_B       (po_data_B),
    .po_data_last    (po_data_last),
    .po_data_wr_en   (po_data_wr_en),
    .pi_res_wr_en    (pi_res_wr_en),
    .pi_res_last     (pi_res_last),
    .po_busy         (po_busy),
    .po_done         (po_done),
    .po_err          (po_err),
    .po_res_limbs    (po_res_limbs)
  );

  always #5 r_clk = ~r_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [c_dw-1:0] a_limb(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  function automatic logic [c_dw-1:0] b_limb(input int i);
    return 64'h5A5A_0000_0000_0000 | 64'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the operand memory answers a read one cycle later.
  task automatic tick();
    logic            en;
    logic [c_aw-1:0] addr;
    en   = po_rd_en;
    addr = po_rd_addr;
    @(posedge r_clk);
    #1;
    if (en === 1'b1) begin
      pi_rd_data_a = a_limb(int'(addr));
      pi_rd_data_b = b_limb(int'(addr));
    end else begin
      pi_rd_data_a = 64'hDEAD_BEEF_0BAD_F00D;
      pi_rd_data_b = 64'hDEAD_BEEF_0BAD_F00D;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " rd_en"},    po_rd_en, 0);
    check({tag, " rd_addr"},  po_rd_addr, 0);
    check({tag, " wr_en"},    po_data_wr_en, 0);
    check({tag, " last"},     po_data_last, 0);
    check({tag, " data_A"},   po_data_A, 0);
    check({tag, " data_B"},   po_data_B, 0);
    check({tag, " valid_n"},  po_ctrl_valid_n, 1);
    check({tag, " ctrl_A"},   po_ctrl_ch_A, 0);
    check({tag, " ctrl_B"},   po_ctrl_ch_B, 0);
    check({tag, " busy"},     po_busy, 0);
    check({tag, " done"},     po_done, 0);
  endtask

  task automatic start_cmd(input logic oper, input logic [7:0] sa, input logic [7:0] sb,
                           input int la, input int lb, input bit keep_valid);
    logic [7:0] w1;
    w1    = 8'(c_id);
    w1[7] = oper;
    check("accept ready", po_cmd_ready, 1);
    pi_cmd_oper  = oper;
    pi_cmd_src_a = sa;
    pi_cmd_src_b = sb;
    pi_cmd_len_a = 9'(la);
    pi_cmd_len_b = 9'(lb);
    pi_cmd_valid = 1'b1;
    tick();
    if (keep_valid) begin
      pi_cmd_oper  = ~oper;
      pi_cmd_src_a = ~sa;
      pi_cmd_src_b = ~sb;
      pi_cmd_len_a = '0;
      pi_cmd_len_b = '0;
    end else begin
      pi_cmd_valid = 1'b0;
    end
    check("ctrl1 valid_n", po_ctrl_valid_n, 0);
    check("ctrl1 ch_A",    po_ctrl_ch_A, w1);
    check("ctrl1 ch_B",    po_ctrl_ch_B, 8'(c_id));
    check("ctrl1 busy",    po_busy, 1);
    check("ctrl1 ready",   po_cmd_ready, 0);
    check("ctrl1 err",     po_err, 0);
    check("ctrl1 limbs",   po_res_limbs, 0);
    tick();
    check("ctrl2 valid_n", po_ctrl_valid_n, 1);
    check("ctrl2 ch_A",    po_ctrl_ch_A, sa);
    check("ctrl2 ch_B",    po_ctrl_ch_B, sb);
    tick();
    check("ctrl3 valid_n", po_ctrl_valid_n, 1);
    check("ctrl3 ch_A",    po_ctrl_ch_A, 0);
    check("ctrl3 ch_B",    po_ctrl_ch_B, 0);
    check("ctrl3 rd_en",   po_rd_en, 0);
    tick();
  endtask

  // Cycle c counts from the first FEED cycle; limb k leaves at c = k + 2.
  task automatic feed(input int la, input int lb, input bit echo, input int res_c);
    int n;
    n = ((la > lb) ? la : lb) + 1;
    for (int c = 0; c <= n + 1; c++) begin
      int k;
      bit v;
      k = c - 2;
      v = (k >= 0) && (k < n);
      check($sformatf("c%0d rd_en", c),   po_rd_en, (c < n) ? 1 : 0);
      check($sformatf("c%0d rd_addr", c), po_rd_addr, (c < n) ? 64'(c) : 0);
      check($sformatf("c%0d wr_en", c),   po_data_wr_en, v ? 1 : 0);
      check($sformatf("c%0d last", c),    po_data_last, (v && k == n - 1) ? 1 : 0);
      check($sformatf("c%0d data_A", c),  po_data_A, (v && k <= la) ? a_limb(k) : 0);
      check($sformatf("c%0d data_B", c),  po_data_B, (v && k <= lb) ? b_limb(k) : 0);
      check($sformatf("c%0d busy", c),    po_busy, 1);
      check($sformatf("c%0d valid_n", c), po_ctrl_valid_n, 1);
      pi_res_wr_en = (echo && v) || (c == res_c);
      pi_res_last  = (echo && v && k == n - 1) || (c == res_c);
      tick();
    end
    pi_res_wr_en = 1'b0;
    pi_res_last  = 1'b0;
  endtask

  task automatic pulse_res_last();
    pi_res_wr_en = 1'b1;
    pi_res_last  = 1'b1;
    tick();
    pi_res_wr_en = 1'b0;
    pi_res_last  = 1'b0;
  endtask

  task automatic done_after(input int rem, input bit exp_err, input int exp_limbs);
    for (int i = 0; i < rem; i++) begin
      check($sformatf("wait%0d done", i), po_done, 0);
      check($sformatf("wait%0d busy", i), po_busy, 1);
      tick();
    end
    check("done pulse", po_done, 1);
    check("done err",   po_err, exp_err);
    check("done limbs", po_res_limbs, exp_limbs);
    tick();
    check("post done",  po_done, 0);
    check("post busy",  po_busy, 0);
    check("post ready", po_cmd_ready, 1);
    check("post err",   po_err, exp_err);
  endtask

  initial begin
    r_rst        = 1'b1;
    pi_cmd_valid = 1'b0;
    pi_cmd_oper  = 1'b0;
    pi_cmd_src_a = '0;
    pi_cmd_src_b = '0;
    pi_cmd_len_a = '0;
    pi_cmd_len_b = '0;
    pi_rd_data_a = '0;
    pi_rd_data_b = '0;
    pi_res_wr_en = 1'b0;
    pi_res_last  = 1'b0;

    tick();
    tick();
    check_quiet("reset");
    check("reset ready", po_cmd_ready, 0);
    check("reset err",   po_err, 0);
    check("reset limbs", po_res_limbs, 0);
    r_rst = 1'b0;
    tick();
    check("release ready", po_cmd_ready, 1);

    // Single-limb add, result arrives in WAIT_RES.
    start_cmd(1'b0, 8'h11, 8'h22, 0, 0, 1'b0);
    feed(0, 0, 1'b0, -1);
    pulse_res_last();
    done_after(c_drain, 1'b0, 1);

    // Subtract with unequal lengths: B masked for limbs 2..4.
    start_cmd(1'b1, 8'h3C, 8'hC3, 4, 1, 1'b0);
    feed(4, 1, 1'b0, -1);
    pulse_res_last();
    done_after(c_drain, 1'b0, 1);

    // Full-size operands; adder echoes every limb, last one lands in WAIT_RES.
    start_cmd(1'b0, 8'h01, 8'h02, 511, 511, 1'b0);
    feed(511, 511, 1'b1, -1);
    done_after(c_drain, 1'b0, 512);

    // Result last during FEED: DRAIN starts at c=3, two DRAIN cycles seen in feed.
    start_cmd(1'b0, 8'h05, 8'h06, 2, 2, 1'b0);
    feed(2, 2, 1'b0, 1);
    done_after(c_drain - 2, 1'b0, 1);

    // No result: WAIT_RES spans c=1..c_tmo, DONE with err at c=c_tmo+1.
    start_cmd(1'b1, 8'h07, 8'h08, 0, 0, 1'b0);
    feed(0, 0, 1'b0, -1);
    done_after(c_tmo - 2, 1'b1, 0);

    // Reset while issuing limb 100 of 300.
    start_cmd(1'b0, 8'h09, 8'h0A, 299, 299, 1'b0);
    for (int c = 0; c <= 100; c++) begin
      check($sformatf("long c%0d rd_addr", c), po_rd_addr, 64'(c));
      if (c < 100) tick();
    end
    r_rst = 1'b1;
    tick();
    check_quiet("mid reset");
    check("mid reset ready", po_cmd_ready, 0);
    r_rst = 1'b0;
    tick();
    check_quiet("after reset");
    check("after reset ready", po_cmd_ready, 1);
    start_cmd(1'b1, 8'h21, 8'h12, 1, 2, 1'b0);
    feed(1, 2, 1'b0, -1);
    pulse_res_last();
    done_after(c_drain, 1'b0, 1);

    // cmd_valid held through busy: one accept now, the next only after DONE.
    start_cmd(1'b0, 8'h44, 8'h55, 0, 0, 1'b1);
    feed(0, 0, 1'b0, -1);
    pulse_res_last();
    done_after(c_drain, 1'b0, 1);
    start_cmd(1'b1, 8'hBB, 8'hAA, 0, 0, 1'b0);
    feed(0, 0, 1'b0, -1);
    pulse_res_last();
    done_after(c_drain, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_op_sequencer.md
ADDER_OP_SEQUENCER -- requirements
Module: adder_op_sequencer

Interface
REQ-001 SHALL have parameter G_DATA_WIDTH, default 64, limb width.
REQ-002 SHALL have parameter G_ADDR_WIDTH, default 9, operand memory address / limb-count width.
REQ-003 SHALL have parameter G_CTRL_WIDTH, default 8, adder control channel width.
REQ-004 SHALL have parameter G_ID, default 3, adder unit ID placed in control word 1.
REQ-005 SHALL have parameter G_DRAIN_CYCLES, default 10, idle cycles after result last before done.
REQ-006 SHALL have parameter G_TIMEOUT, default 2048, max cycles in WAIT_RES before error.
REQ-007 SHALL have ports r_clk in 1 clock; r_rst in 1 reset, synchronous, active-high.
REQ-008 SHALL have ports pi_cmd_valid in 1; po_cmd_ready out 1; pi_cmd_oper in 1 (0 add, 1 sub).
REQ-009 SHALL have ports pi_cmd_src_a, pi_cmd_src_b in G_CTRL_WIDTH, source register IDs.
REQ-010 SHALL have ports pi_cmd_len_a, pi_cmd_len_b in G_ADDR_WIDTH, limb count minus one.
REQ-011 SHALL have ports po_rd_en out 1; po_rd_addr out G_ADDR_WIDTH; pi_rd_data_a, pi_rd_data_b in G_DATA_WIDTH, valid 1 cycle after po_rd_en.
REQ-012 SHALL have ports po_ctrl_ch_A, po_ctrl_ch_B out G_CTRL_WIDTH; po_ctrl_valid_n out 1.
REQ-013 SHALL have ports po_data_A, po_data_B out G_DATA_WIDTH; po_data_last out 1; po_data_wr_en out 1.
REQ-014 SHALL have ports pi_res_wr_en, pi_res_last in 1, adder result strobes.
REQ-015 SHALL have ports po_busy out 1; po_done out 1 pulse; po_err out 1; po_res_limbs out G_ADDR_WIDTH+1.

Function
REQ-016 SHALL implement states IDLE, CTRL_1, CTRL_2, CTRL_3, FEED, WAIT_RES, DRAIN, DONE.
REQ-017 po_cmd_ready SHALL be 1 only in IDLE; command captured on pi_cmd_valid & po_cmd_ready, IDLE->CTRL_1.
REQ-018 CTRL_1 SHALL drive po_ctrl_valid_n=0, po_ctrl_ch_A={oper, G_ID[G_CTRL_WIDTH-2:0]}, po_ctrl_ch_B=G_ID.
REQ-019 CTRL_2 SHALL drive po_ctrl_valid_n=1, po_ctrl_ch_A=src_a, po_ctrl_ch_B=src_b; CTRL_3 SHALL drive both channels 0.
REQ-020 Outside CTRL_1/CTRL_2, control channels SHALL be 0 and po_ctrl_valid_n SHALL be 1.
REQ-021 FEED SHALL issue po_rd_en=1 with po_rd_addr=0,1,...,N-1 on consecutive cycles, N=max(len_a,len_b)+1, no gaps.
REQ-022 Limb i SHALL appear on po_data_A/B with po_data_wr_en=1 exactly 2 cycles after its read issue (registered output).
REQ-023 po_data_A SHALL be 0 for i>len_a; po_data_B SHALL be 0 for i>len_b.
REQ-024 po_data_last SHALL be 1 only with limb N-1; wr_en, last, data SHALL be 0 when no limb valid.
REQ-025 FEED->WAIT_RES SHALL occur after last read issue; the 2-cycle pipeline SHALL drain regardless of state.
REQ-026 po_res_limbs SHALL clear on command accept and increment on each pi_res_wr_en.
REQ-027 pi_res_wr_en & pi_res_last SHALL move WAIT_RES->DRAIN; also honoured if it arrives during FEED.
REQ-028 DRAIN SHALL last G_DRAIN_CYCLES cycles, then DONE; DONE SHALL pulse po_done=1 one cycle and return IDLE.
REQ-029 WAIT_RES exceeding G_TIMEOUT cycles SHALL set po_err=1 and go DONE; po_err clears on next accept.
REQ-030 po_busy SHALL be 1 in every state except IDLE.
REQ-031 pi_cmd_valid outside IDLE SHALL be ignored (not queued).

Reset
REQ-032 r_rst SHALL force IDLE from any state, including mid-FEED, and flush the read pipeline.
REQ-033 Reset values: po_cmd_ready=0 during reset, 1 the cycle after; all other outputs 0 except po_ctrl_valid_n=1.

Structure
REQ-034 Package adder_seq_pkg SHALL hold the state enum, control-word layout constants and default parameter values.
REQ-035 One sub-module adder_seq_limb_pipe SHALL hold the 2-stage read/zero-mask/last pipeline; FSM and counters in top.

Verification
REQ-036 Add, len_a=0, len_b=0: ctrl_valid_n low 1 cycle with ctrl_A={0,G_ID}; one limb, wr_en=1, last=1; res last -> done 10 cycles later.
REQ-037 Sub, len_a=4, len_b=1: ctrl_A MSB=1; 5 limbs, B zero for limbs 2..4, last on limb 4 only.
REQ-038 len_a=len_b=511: 512 back-to-back wr_en cycles, po_rd_addr wraps never, po_res_limbs counts 512 or 513.
REQ-039 No pi_res_last after feed: po_err=1 and po_done pulse at G_TIMEOUT+1 cycles into WAIT_RES.
REQ-040 r_rst asserted at limb 100 of 300: next cycle all outputs idle, cmd_ready=1 after release, new command runs cleanly.
REQ-041 pi_cmd_valid held high during busy: exactly one command accepted per IDLE visit.
